enemy_shot_ctl: RTL
===================

// Module: enemy_shot_ctl
// PURPOSE
//  Invader-side fire controller, the downward counterpart of the player shot logic.
//  - Periodically picks a random surviving alien column and spawns a bomb below the formation.
//  - Moves the bomb down the screen at a fixed step per movement tick.
//  - Detects a hit on the player sprite, signals it, and retires the bomb.
//  - Sits beside the formation controller; feeds bomb sprite drawing and game-state logic.
// PARAMETERS
//  COLS          11      alien columns in formation
//  COL_PITCH     48      horizontal px between column origins
//  ALIEN_WIDTH   32      alien sprite width, px
//  PLAYER_WIDTH  32      player sprite width, px
//  PLAYER_HEIGHT 32      player sprite height, px (player row = bottom of screen)
//  BOMB_WIDTH    8       bomb sprite width, px
//  BOMB_HEIGHT   16      bomb sprite height, px
//  BOMB_SPEED    3       px the bomb falls per tick
//  FIRE_INTERVAL 40      ticks between bomb retire and next spawn attempt
//  TICK_DIV      650000  clk cycles per movement tick, minus one
// PORTS
//  clk                 in   1     system clock
//  rst_n               in   1     asynchronous, active-low reset
//  game_active         in   1     1 = play running; 0 = abort/hold
//  formation_x         in   12    x of column 0 left edge
//  formation_bottom_y  in   12    y just below lowest alien row
//  col_alive           in   COLS  bit i = column i has >=1 live alien
//  player_xpos         in   12    player sprite left edge
//  bomb_clear          in   1     1-clk pulse: bomb destroyed externally (e.g. by player bullet)
//  bomb_active         out  1     bomb on screen
//  bomb_x              out  12    bomb left edge
//  bomb_y              out  12    bomb top edge
//  player_hit          out  1     1-clk pulse on bomb/player overlap
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - bomb_active=0, bomb_x=0, bomb_y=0, player_hit=0.
//    - state=IDLE, cooldown=FIRE_INTERVAL, tick counter=0, LFSR=8'hA5.
//  - Tick:
//    - Free-running counter 0..TICK_DIV; tick=1 for one clk when it wraps.
//    - Period is TICK_DIV+1 clks.
//  - LFSR:
//    - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
//    - Advances every clk; never reaches zero.
//  - States:
//    - IDLE:
//      - On tick with game_active: cooldown decrements.
//      - At 0: start index = LFSR mod COLS, go to SELECT.
//    - SELECT:
//      - Checks one column per clk, starting at the start index, wrapping COLS-1 -> 0.
//      - First alive column c:
//        - bomb_x = formation_x + c*COL_PITCH + ALIEN_WIDTH/2 - BOMB_WIDTH/2.
//        - bomb_y = formation_bottom_y; bomb_active=1; go to FALL.
//      - COLS columns checked with none alive: reload cooldown, go to IDLE. No bomb.
//    - FALL, on each tick:
//      - y_n = bomb_y + BOMB_SPEED.
//      - Hit:
//        - Condition: y_n+BOMB_HEIGHT >= VER_PIXELS-PLAYER_HEIGHT, AND bomb_x+BOMB_WIDTH > player_xpos, AND bomb_x < player_xpos+PLAYER_WIDTH.
//        - Action: player_hit=1 for exactly one clk, bomb_active=0, reload cooldown, go to IDLE.
//      - Else if y_n >= VER_PIXELS: bomb_active=0, reload cooldown, go to IDLE. No hit.
//      - Else bomb_y = y_n.
//  - Arithmetic:
//    - All position sums and compares use 13 bits, so nothing wraps.
//    - bomb_x and bomb_y outputs are truncated to 12 bits.
//    - Column offset comes from a constant multiply; no runtime multiplier.
//  - Priority when events coincide in the same clk: game_active=0 > bomb_clear > hit > off-screen.
//    - bomb_clear in FALL: bomb_active=0 next clk, no player_hit, reload cooldown, IDLE.
//    - game_active=0 in any state: next clk bomb_active=0, player_hit=0, state IDLE, cooldown reloaded.
//    - bomb_clear outside FALL is ignored.
//  - Only one bomb in flight at a time.
//  - Outputs are registered, with no combinational input-to-output path.
//  - Changes to formation_x during FALL do not move the bomb; the spawn position is latched.
// STRUCTURE
//  - vga_pkg supplies HOR_PIXELS and VER_PIXELS.
//  - game_pkg holds shared sprite dimensions and the enemy_shot_state_e enum {IDLE, SELECT, FALL}.
//  - One sub-module, lfsr8: clk, rst_n, seed, out[7:0].
//    - Reused by the formation controller for random march effects.
// TESTING
//  Bench config: TICK_DIV=1, FIRE_INTERVAL=2, COLS=11.
//  1. Reset with formation_x=100, formation_bottom_y=200, col_alive=all ones.
//     -> All outputs 0 through reset.
//     -> After 2 ticks plus the SELECT clks: bomb_active=1, bomb_y=200, bomb_x = 100+48c+12 for the chosen c.
//  2. col_alive=11'b000_0010_0000 (only column 5 alive), formation_x=0.
//     -> Every spawn has bomb_x=252.
//     -> col_alive=0: no spawn, bomb_active stays 0 indefinitely.
//  3. player_xpos = bomb_x-4, bomb falling.
//     -> player_hit is high for exactly 1 clk on the tick where bomb bottom reaches VER_PIXELS-32.
//     -> bomb_active=0 on the same clk edge.
//  4. player_xpos = bomb_x+100.
//     -> No player_hit.
//     -> bomb retires on the first tick with y_n >= VER_PIXELS.
//     -> Next spawn follows FIRE_INTERVAL ticks later.
//  5. bomb_clear on the same tick as a hit condition.
//     -> player_hit stays 0, bomb_active=0.
//  6. rst_n asserted mid-FALL, between clk edges.
//     -> bomb_active=0 immediately (async).
//     -> After release, the first spawn waits the full FIRE_INTERVAL.
//     -> game_active=0 mid-FALL clears the bomb within 1 clk.

Source files
------------

// File: rtl/game_pkg.sv
// Sprite dimensions shared by the game blocks and the state encoding
// of the invader fire controller.
package game_pkg;

  localparam int ALIEN_WIDTH   = 32;
  localparam int PLAYER_WIDTH  = 32;
  localparam int PLAYER_HEIGHT = 32;
  localparam int BOMB_WIDTH    = 8;
  localparam int BOMB_HEIGHT   = 16;

  // IDLE   : counting cooldown ticks before the next fire attempt
  // SELECT : scanning columns for one that still has a live alien
  // FALL   : bomb on screen, moving down once per tick
  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    FALL
  } enemy_shot_state_e;

endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by every sprite and position block.
//   HOR_PIXELS : visible columns
//   VER_PIXELS : visible rows; the player row sits at the bottom
package vga_pkg;

  localparam int HOR_PIXELS = 640;
  localparam int VER_PIXELS = 480;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length).
// Steps every clock. A nonzero seed never reaches the all-zero state.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, loads seed
//   seed  : reset value, must be nonzero
//   out   : current register value
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  // Taps 8,6,5,4 map to bits 7,5,4,3; the feedback enters at bit 0.
  always_comb begin
    feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = {lfsr_q[6:0], feedback};
  end

  // The register free-runs so the pick depends on when a fire attempt lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/enemy_shot_ctl.sv
// Invader fire controller: after a cooldown it picks a random surviving
// column, drops one bomb from below the formation, moves it down once per
// movement tick and reports a hit when it overlaps the player sprite.
//   clk, rst_n         : clock, asynchronous active-low reset
//   game_active        : 1 = play running, 0 = abort and hold
//   formation_x        : left edge of column 0
//   formation_bottom_y : row just below the lowest alien row
//   col_alive          : bit i set when column i still has a live alien
//   player_xpos        : player sprite left edge
//   bomb_clear         : one-clock pulse, bomb destroyed elsewhere
//   bomb_active        : bomb on screen
//   bomb_x, bomb_y     : bomb top-left corner
//   player_hit         : one-clock pulse on bomb/player overlap
module enemy_shot_ctl
  import vga_pkg::*;
  import game_pkg::*;
#(
  parameter int COLS          = 11,
  parameter int COL_PITCH     = 48,
  parameter int ALIEN_WIDTH   = game_pkg::ALIEN_WIDTH,
  parameter int PLAYER_WIDTH  = game_pkg::PLAYER_WIDTH,
  parameter int PLAYER_HEIGHT = game_pkg::PLAYER_HEIGHT,
  parameter int BOMB_WIDTH    = game_pkg::BOMB_WIDTH,
  parameter int BOMB_HEIGHT   = game_pkg::BOMB_HEIGHT,
  parameter int BOMB_SPEED    = 3,
  parameter int FIRE_INTERVAL = 40,
  parameter int TICK_DIV      = 650000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            game_active,
  input  logic [11:0]     formation_x,
  input  logic [11:0]     formation_bottom_y,
  input  logic [COLS-1:0] col_alive,
  input  logic [11:0]     player_xpos,
  input  logic            bomb_clear,
  output logic            bomb_active,
  output logic [11:0]     bomb_x,
  output logic [11:0]     bomb_y,
  output logic            player_hit
);

  localparam int TICK_W   = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);
  localparam int CD_W     = (FIRE_INTERVAL < 1) ? 1 : $clog2(FIRE_INTERVAL + 1);
  localparam int COL_W    = (COLS < 2) ? 1 : $clog2(COLS);
  localparam int X_CENTER = ALIEN_WIDTH / 2 - BOMB_WIDTH / 2;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV);
  localparam logic [CD_W-1:0]   CD_RELOAD  = CD_W'(FIRE_INTERVAL);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
  localparam logic [12:0]       HIT_ROW    = 13'(VER_PIXELS - PLAYER_HEIGHT);
  localparam logic [12:0]       SCREEN_END = 13'(VER_PIXELS);

  enemy_shot_state_e state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [CD_W-1:0]   cooldown_q, cooldown_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [COL_W-1:0]  checked_q, checked_d;
  logic [11:0]       bomb_x_q, bomb_x_d;
  logic [11:0]       bomb_y_q, bomb_y_d;
  logic              active_q, active_d;
  logic              hit_q, hit_d;

  logic              tick;
  logic [7:0]        lfsr_out;
  logic [COL_W-1:0]  start_col;
  logic [12:0]       col_offset;
  logic [12:0]       spawn_x;
  logic [12:0]       y_next;
  logic              hit_cond;
  logic              unused_spawn_msb;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (8'hA5),
    .out   (lfsr_out)
  );

  // Movement tick: one clock out of every TICK_DIV+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Position arithmetic is carried in 13 bits so sums near the screen
  // edge cannot wrap before the compares see them. The column offset is
  // a multiply by a constant pitch, which reduces to shifts and adds.
  always_comb begin
    start_col  = COL_W'(lfsr_out % 8'(COLS));
    col_offset = 13'(col_idx_q) * 13'(COL_PITCH);
    spawn_x    = {1'b0, formation_x} + col_offset + 13'(X_CENTER);
    y_next     = {1'b0, bomb_y_q} + 13'(BOMB_SPEED);
    hit_cond   = (y_next + 13'(BOMB_HEIGHT) >= HIT_ROW) &&
                 ({1'b0, bomb_x_q} + 13'(BOMB_WIDTH) > {1'b0, player_xpos}) &&
                 ({1'b0, bomb_x_q} < {1'b0, player_xpos} + 13'(PLAYER_WIDTH));
  end

  assign unused_spawn_msb = spawn_x[12];

  // Next-state logic. game_active=0 overrides everything; in FALL an
  // external clear beats a hit, which beats leaving the screen. Every
  // path that retires a bomb reloads the full cooldown.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    col_idx_d  = col_idx_q;
    checked_d  = checked_q;
    bomb_x_d   = bomb_x_q;
    bomb_y_d   = bomb_y_q;
    active_d   = active_q;
    hit_d      = 1'b0;

    if (!game_active) begin
      state_d    = IDLE;
      active_d   = 1'b0;
      cooldown_d = CD_RELOAD;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            if (cooldown_q <= CD_W'(1)) begin
              cooldown_d = '0;
              col_idx_d  = start_col;
              checked_d  = '0;
              state_d    = SELECT;
            end else begin
              cooldown_d = cooldown_q - 1'b1;
            end
          end
        end

        SELECT: begin
          if (col_alive[col_idx_q]) begin
            bomb_x_d = spawn_x[11:0];
            bomb_y_d = formation_bottom_y;
            active_d = 1'b1;
            state_d  = FALL;
          end else if (checked_q == COL_LAST) begin
            cooldown_d = CD_RELOAD;
            state_d    = IDLE;
          end else begin
            checked_d = checked_q + 1'b1;
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
          end
        end

        FALL: begin
          if (bomb_clear) begin
            active_d   = 1'b0;
            cooldown_d = CD_RELOAD;
            state_d    = IDLE;
          end else if (tick) begin
            if (hit_cond) begin
              hit_d      = 1'b1;
              active_d   = 1'b0;
              cooldown_d = CD_RELOAD;
              state_d    = IDLE;
            end else if (y_next >= SCREEN_END) begin
              active_d   = 1'b0;
              cooldown_d = CD_RELOAD;
              state_d    = IDLE;
            end else begin
              bomb_y_d = y_next[11:0];
            end
          end
        end

        default: begin
          state_d    = IDLE;
          active_d   = 1'b0;
          cooldown_d = CD_RELOAD;
        end
      endcase
    end
  end

  // State and output registers; outputs come straight from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cooldown_q <= CD_RELOAD;
      col_idx_q  <= '0;
      checked_q  <= '0;
      bomb_x_q   <= '0;
      bomb_y_q   <= '0;
      active_q   <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      col_idx_q  <= col_idx_d;
      checked_q  <= checked_d;
      bomb_x_q   <= bomb_x_d;
      bomb_y_q   <= bomb_y_d;
      active_q   <= active_d;
      hit_q      <= hit_d;
    end
  end

  assign bomb_active = active_q;
  assign bomb_x      = bomb_x_q;
  assign bomb_y      = bomb_y_q;
  assign player_hit  = hit_q;

endmodule
